// File: rtl/sensor_frame_assembler.sv
// Stages BNO085 quaternion/gyro samples and button events, then publishes
// a checksummed 32-byte frame to the MCU SPI slave over ready/ack.
module sensor_frame_assembler #(
    parameter int unsigned MIN_GAP_CYCLES   = 3000,
    parameter int unsigned KEEPALIVE_CYCLES = 300000,
    parameter logic [7:0]  HEADER_BYTE      = 8'hAA
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               quat1_valid,
    input  logic signed [15:0] quat1_w,
    input  logic signed [15:0] quat1_x,
    input  logic signed [15:0] quat1_y,
    input  logic signed [15:0] quat1_z,
    input  logic               gyro1_valid,
    input  logic signed [15:0] gyro1_x,
    input  logic signed [15:0] gyro1_y,
    input  logic signed [15:0] gyro1_z,
    input  logic               quat2_valid,
    input  logic signed [15:0] quat2_w,
    input  logic signed [15:0] quat2_x,
    input  logic signed [15:0] quat2_y,
    input  logic signed [15:0] quat2_z,
    input  logic               gyro2_valid,
    input  logic signed [15:0] gyro2_x,
    input  logic signed [15:0] gyro2_y,
    input  logic signed [15:0] gyro2_z,
    input  logic               calibrate_btn_pulse,
    input  logic               kick_btn_pulse,
    output logic [31:0][7:0]   data_bytes,
    output logic               data_ready,
    input  logic               data_ack
);

    localparam int GW = $clog2(MIN_GAP_CYCLES + 1);
    localparam int KW = $clog2(KEEPALIVE_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(MIN_GAP_CYCLES - 1);
    localparam logic [KW-1:0] KA_LAST  = KW'(KEEPALIVE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LATCH, READY} state_t;

    state_t            state_r;
    logic [13:0][15:0] stage_r;
    logic [3:0]        fresh_r;
    logic              cal_r;
    logic              kick_r;
    logic              ovr_r;
    logic [7:0]        seq_r;
    logic [GW-1:0]     gap_r;
    logic [KW-1:0]     ka_r;
    logic [3:0]        valid;
    logic              latch;
    logic              pending;
    logic [31:0][7:0]  frame;
    logic [7:0]        csum;

    assign valid   = {gyro2_valid, quat2_valid, gyro1_valid, quat1_valid};
    assign latch   = (state_r == LATCH);
    assign pending = (|fresh_r) | cal_r | kick_r | ovr_r | (ka_r == KA_LAST);

    // Staging words 0-3 q1, 4-6 g1, 7-10 q2, 11-13 g2; each sent MSB first
    always_comb begin
        frame    = '0;
        frame[0] = HEADER_BYTE;
        frame[1] = seq_r;
        frame[2] = {1'b0, ovr_r, kick_r, cal_r, fresh_r};
        for (int k = 0; k < 14; k++) begin
            frame[3 + 2*k] = stage_r[k][15:8];
            frame[4 + 2*k] = stage_r[k][7:0];
        end
        csum = '0;
        for (int i = 0; i < 31; i++) begin
            csum = csum ^ frame[i];
        end
        frame[31] = csum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            stage_r    <= '0;
            fresh_r    <= '0;
            cal_r      <= 1'b0;
            kick_r     <= 1'b0;
            ovr_r      <= 1'b0;
            seq_r      <= '0;
            gap_r      <= '0;
            ka_r       <= '0;
            data_bytes <= '0;
            data_ready <= 1'b0;
        end else begin
            if (quat1_valid) stage_r[3:0]   <= {quat1_z, quat1_y, quat1_x, quat1_w};
            if (gyro1_valid) stage_r[6:4]   <= {gyro1_z, gyro1_y, gyro1_x};
            if (quat2_valid) stage_r[10:7]  <= {quat2_z, quat2_y, quat2_x, quat2_w};
            if (gyro2_valid) stage_r[13:11] <= {gyro2_z, gyro2_y, gyro2_x};

            // Events landing in LATCH survive the clear and go to the next frame
            fresh_r <= (latch ? 4'b0 : fresh_r) | valid;
            ovr_r   <= latch ? 1'b0 : (ovr_r | (|(valid & fresh_r)));
            cal_r   <= (cal_r & ~latch) | calibrate_btn_pulse;
            kick_r  <= (kick_r & ~latch) | kick_btn_pulse;

            if (gap_r != '0) gap_r <= gap_r - 1'b1;

            unique case (state_r)
                IDLE: begin
                    if (ka_r != KA_LAST) ka_r <= ka_r + 1'b1;
                    if (gap_r == '0 && pending) state_r <= LATCH;
                end
                LATCH: begin
                    data_bytes <= frame;
                    seq_r      <= seq_r + 8'd1;
                    gap_r      <= GAP_LOAD;
                    ka_r       <= '0;
                    data_ready <= 1'b1;
                    state_r    <= READY;
                end
                READY: begin
                    if (data_ack) begin
                        data_ready <= 1'b0;
                        state_r    <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_frame_assembler.sv
// Bench for sensor_frame_assembler: directed steps with random sample data
// checked against a frame model built from byte queues.
module tb_sensor_frame_assembler;

    localparam int MIN_GAP = 20;
    localparam int KEEPALIVE = 50;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic quat1_valid = 1'b0, gyro1_valid = 1'b0;
    logic quat2_valid = 1'b0, gyro2_valid = 1'b0;
    logic signed [15:0] quat1_w = 0, quat1_x = 0, quat1_y = 0, quat1_z = 0;
    logic signed [15:0] gyro1_x = 0, gyro1_y = 0, gyro1_z = 0;
    logic signed [15:0] quat2_w = 0, quat2_x = 0, quat2_y = 0, quat2_z = 0;
    logic signed [15:0] gyro2_x = 0, gyro2_y = 0, gyro2_z = 0;
    logic calibrate_btn_pulse = 1'b0, kick_btn_pulse = 1'b0;
    logic [31:0][7:0] data_bytes;
    logic data_ready;
    logic data_ack = 1'b0;

    sensor_frame_assembler #(
        .MIN_GAP_CYCLES(MIN_GAP),
        .KEEPALIVE_CYCLES(KEEPALIVE),
        .HEADER_BYTE(8'hAA)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .quat1_valid(quat1_valid), .quat1_w(quat1_w), .quat1_x(quat1_x),
        .quat1_y(quat1_y), .quat1_z(quat1_z),
        .gyro1_valid(gyro1_valid), .gyro1_x(gyro1_x), .gyro1_y(gyro1_y),
        .gyro1_z(gyro1_z),
        .quat2_valid(quat2_valid), .quat2_w(quat2_w), .quat2_x(quat2_x),
        .quat2_y(quat2_y), .quat2_z(quat2_z),
        .gyro2_valid(gyro2_valid), .gyro2_x(gyro2_x), .gyro2_y(gyro2_y),
        .gyro2_z(gyro2_z),
        .calibrate_btn_pulse(calibrate_btn_pulse),
        .kick_btn_pulse(kick_btn_pulse),
        .data_bytes(data_bytes), .data_ready(data_ready), .data_ack(data_ack)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Reference state: what the next published frame should contain
    logic [15:0] m_stage [14];
    logic [3:0]  m_fresh;
    logic        m_cal, m_kick, m_ovr;
    logic [7:0]  m_seq;
    logic [31:0][7:0] exp_f;

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic model_reset();
        foreach (m_stage[k]) m_stage[k] = '0;
        m_fresh = '0;
        m_cal = 0; m_kick = 0; m_ovr = 0;
        m_seq = '0;
    endtask

    task automatic model_publish(output logic [31:0][7:0] f);
        logic [7:0] q[$];
        logic [7:0] x;
        q.push_back(8'hAA);
        q.push_back(m_seq);
        q.push_back({1'b0, m_ovr, m_kick, m_cal, m_fresh});
        foreach (m_stage[k]) begin
            q.push_back(m_stage[k][15:8]);
            q.push_back(m_stage[k][7:0]);
        end
        x = 8'h00;
        foreach (q[i]) x = x ^ q[i];
        q.push_back(x);
        for (int i = 0; i < 32; i++) f[i] = q[i];
        m_fresh = '0;
        m_cal = 0; m_kick = 0; m_ovr = 0;
        m_seq = m_seq + 8'd1;
    endtask

    // Drive one group's valid and data for the coming edge; record in model
    task automatic ev(input int g, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] c, input logic [15:0] d);
        int base;
        int len;
        logic [15:0] w[4];
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
        case (g)
            0: begin quat1_valid = 1; quat1_w = a; quat1_x = b;
                     quat1_y = c; quat1_z = d; base = 0; len = 4; end
            1: begin gyro1_valid = 1; gyro1_x = a; gyro1_y = b;
                     gyro1_z = c; base = 4; len = 3; end
            2: begin quat2_valid = 1; quat2_w = a; quat2_x = b;
                     quat2_y = c; quat2_z = d; base = 7; len = 4; end
            default: begin gyro2_valid = 1; gyro2_x = a; gyro2_y = b;
                     gyro2_z = c; base = 11; len = 3; end
        endcase
        if (m_fresh[g]) m_ovr = 1;
        m_fresh[g] = 1;
        for (int i = 0; i < len; i++) m_stage[base + i] = w[i];
    endtask

    task automatic ev_rand(input int g);
        ev(g, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    endtask

    task automatic btn(input logic c, input logic k);
        calibrate_btn_pulse = c;
        kick_btn_pulse = k;
        m_cal = m_cal | c;
        m_kick = m_kick | k;
    endtask

    task automatic clear_in();
        quat1_valid = 0; gyro1_valid = 0; quat2_valid = 0; gyro2_valid = 0;
        calibrate_btn_pulse = 0; kick_btn_pulse = 0; data_ack = 0;
    endtask

    task automatic ack();
        data_ack = 1;
        tick();
        data_ack = 0;
    endtask

    task automatic wait_ready(input int max, output int n);
        n = 0;
        while (!data_ready && n < max) begin
            tick();
            n++;
        end
        chk("ready_within_budget", 256'(data_ready), 256'(1));
    endtask

    initial begin
        int n;
        int lat1, lat2;
        logic [7:0] prev_seq;
        model_reset();

        // Reset state
        tick(); tick();
        chk("rst_ready", 256'(data_ready), 256'(0));
        chk("rst_bytes", data_bytes, 256'(0));
        rst_n = 1;
        tick(); tick();
        chk("idle_ready", 256'(data_ready), 256'(0));

        // Single quat1 sample: ready exactly three cycles later
        ev(0, 16'h1234, 16'hFFFE, 16'h0000, 16'h0001);
        tick(); clear_in();
        chk("lat_n1", 256'(data_ready), 256'(0));
        tick();
        chk("lat_n2", 256'(data_ready), 256'(0));
        tick();
        chk("lat_n3", 256'(data_ready), 256'(1));
        lat1 = cyc - 1;
        model_publish(exp_f);
        chk("t1_frame", data_bytes, exp_f);
        chk("t1_b0", 256'(data_bytes[0]), 256'(8'hAA));
        chk("t1_b1", 256'(data_bytes[1]), 256'(8'h00));
        chk("t1_b2", 256'(data_bytes[2]), 256'(8'h01));
        chk("t1_b34", 256'({data_bytes[3], data_bytes[4]}), 256'(16'h1234));
        chk("t1_b56", 256'({data_bytes[5], data_bytes[6]}), 256'(16'hFFFE));
        chk("t1_b31", 256'(data_bytes[31]), 256'(exp_f[31]));
        ack();
        chk("t1_ack", 256'(data_ready), 256'(0));

        // Stray ack while idle is ignored; gyro2 at LATCH+5 waits for gap
        ack();
        chk("stray_ack", 256'(data_ready), 256'(0));
        while (cyc < lat1 + 5) tick();
        ev_rand(3);
        tick(); clear_in();
        wait_ready(100, n);
        lat2 = cyc - 1;
        chk("t2_gap", 256'(lat2 - lat1), 256'(MIN_GAP + 1));
        model_publish(exp_f);
        chk("t2_frame", data_bytes, exp_f);
        chk("t2_flags", 256'(data_bytes[2]), 256'(8'h08));
        chk("t2_seq", 256'(data_bytes[1]), 256'(8'h01));

        // Two quat1 samples during READY: frame frozen, next holds newest
        ev_rand(0); tick(); clear_in();
        ev_rand(0); tick(); clear_in();
        chk("t3_hold_rdy", 256'(data_ready), 256'(1));
        chk("t3_frozen", data_bytes, exp_f);
        ack();
        wait_ready(100, n);
        model_publish(exp_f);
        chk("t3_frame", data_bytes, exp_f);
        chk("t3_flags", 256'(data_bytes[2]), 256'(8'h41));

        // Kick and ack both land in the LATCH cycle
        ack();
        repeat (25) tick();
        ev_rand(1); tick(); clear_in();
        tick();
        model_publish(exp_f);
        btn(0, 1);
        data_ack = 1;
        tick(); clear_in();
        chk("t4_ready", 256'(data_ready), 256'(1));
        chk("t4_frame", data_bytes, exp_f);
        chk("t4_kick0", 256'(data_bytes[2][5]), 256'(0));
        tick();
        chk("t4_ack_in_latch", 256'(data_ready), 256'(1));
        ack();
        wait_ready(100, n);
        model_publish(exp_f);
        chk("t4_next_frame", data_bytes, exp_f);
        chk("t4_kick1", 256'(data_bytes[2]), 256'(8'h20));

        // Keepalive with no input
        ack();
        wait_ready(200, n);
        chk("t5_wait", 256'(n), 256'(KEEPALIVE + 1));
        model_publish(exp_f);
        chk("t5_frame", data_bytes, exp_f);
        chk("t5_flags", 256'(data_bytes[2]), 256'(8'h00));

        // 256 random frames across the seq wrap
        prev_seq = data_bytes[1];
        for (int it = 0; it < 256; it++) begin
            ack();
            for (int e = 0; e < int'($urandom_range(3, 1)); e++) begin
                if ($urandom_range(4, 0) == 4)
                    btn(1'($urandom), 1'($urandom));
                else
                    ev_rand(int'($urandom_range(3, 0)));
                tick(); clear_in();
            end
            wait_ready(200, n);
            model_publish(exp_f);
            chk("t6_frame", data_bytes, exp_f);
            if (prev_seq == 8'hFF)
                chk("t6_wrap", 256'(data_bytes[1]), 256'(8'h00));
            prev_seq = data_bytes[1];
            if ($urandom_range(1, 0) == 1) begin
                ev_rand(int'($urandom_range(3, 0)));
                tick(); clear_in();
                chk("t6_frozen", data_bytes, exp_f);
            end
        end

        // Reset while READY drops the frame at once
        rst_n = 0;
        #1;
        chk("t6_rst_ready", 256'(data_ready), 256'(0));
        chk("t6_rst_bytes", data_bytes, 256'(0));
        tick();
        rst_n = 1;
        model_reset();
        tick();
        ev_rand(2); tick(); clear_in();
        wait_ready(20, n);
        model_publish(exp_f);
        chk("post_rst_frame", data_bytes, exp_f);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
